rv32i_rf_write_arbiter: RTL and testbench

RV32I_RF_WRITE_ARBITER -- requirements
Module: rv32i_rf_write_arbiter

---
 rtl/rv32i_pkg.sv | 19 +
 rtl/rv32i_rf_write_arbiter_if.sv | 53 +++++
 rtl/rv32i_rf_bypass.sv | 36 +++
 rtl/rv32i_rf_write_arbiter.sv | 116 +++++++++++
 tb/tb_rv32i_rf_write_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared RV32I datapath widths and arbiter state encoding.
// Revision    : 1.0
// ============================================================================
package rv32i_pkg;

  localparam int unsigned C_WIDTH        = 32;
  localparam int unsigned C_ADDR_WIDTH   = 5;
  localparam int unsigned C_STARVE_LIMIT = 4;

  typedef enum logic [0:0] {
    ARB_WB = 1'b0,
    ARB_MD = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rv32i_rf_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_rf_write_arbiter_if
// Description : Writeback / mul-div request and register-file port bundle.
// Revision    : 1.0
// ============================================================================
interface rv32i_rf_write_arbiter_if
  import rv32i_pkg::*;
#(
  parameter int unsigned WIDTH      = C_WIDTH,
  parameter int unsigned ADDR_WIDTH = C_ADDR_WIDTH
);

  logic                  i_wb_valid;
  logic [ADDR_WIDTH-1:0] i_wb_rd_addr;
  logic [WIDTH-1:0]      i_wb_rd_data;
  logic                  o_wb_ready;
  logic                  i_md_valid;
  logic [ADDR_WIDTH-1:0] i_md_rd_addr;
  logic [WIDTH-1:0]      i_md_rd_data;
  logic                  o_md_ready;
  logic                  o_rf_we;
  logic [ADDR_WIDTH-1:0] o_rf_rd_addr;
  logic [WIDTH-1:0]      o_rf_rd_data;
  logic [ADDR_WIDTH-1:0] i_rs1_addr;
  logic [ADDR_WIDTH-1:0] i_rs2_addr;
  logic [WIDTH-1:0]      i_rf_rs1_data;
  logic [WIDTH-1:0]      i_rf_rs2_data;
  logic [WIDTH-1:0]      o_rs1_data;
  logic [WIDTH-1:0]      o_rs2_data;

  modport slave (
    input  i_wb_valid, i_wb_rd_addr, i_wb_rd_data,
    output o_wb_ready,
    input  i_md_valid, i_md_rd_addr, i_md_rd_data,
    output o_md_ready,
    output o_rf_we, o_rf_rd_addr, o_rf_rd_data,
    input  i_rs1_addr, i_rs2_addr, i_rf_rs1_data, i_rf_rs2_data,
    output o_rs1_data, o_rs2_data
  );

  modport master (
    output i_wb_valid, i_wb_rd_addr, i_wb_rd_data,
    input  o_wb_ready,
    output i_md_valid, i_md_rd_addr, i_md_rd_data,
    input  o_md_ready,
    input  o_rf_we, o_rf_rd_addr, o_rf_rd_data,
    output i_rs1_addr, i_rs2_addr, i_rf_rs1_data, i_rf_rs2_data,
    input  o_rs1_data, o_rs2_data
  );

endinterface
`default_nettype wire

// File: rtl/rv32i_rf_bypass.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_rf_bypass
// Description : Per-read-port forwarding of the pending RF write.
//               Forwarding active only with RF_WRITE_BYPASS_EN defined.
// Revision    : 1.0
// ============================================================================
module rv32i_rf_bypass
  import rv32i_pkg::*;
#(
  parameter int unsigned WIDTH      = C_WIDTH,
  parameter int unsigned ADDR_WIDTH = C_ADDR_WIDTH
) (
  input  logic                  i_rf_we,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_rs_addr,
  input  logic [WIDTH-1:0]      i_rs_data,
  output logic [WIDTH-1:0]      o_rs_data
);

`ifdef RF_WRITE_BYPASS_EN
  logic w_hit;

  // x0 is hardwired to zero, so it never forwards
  assign w_hit     = i_rf_we && (i_wr_addr == i_rs_addr) && (i_rs_addr != '0);
  assign o_rs_data = w_hit ? i_wr_data : i_rs_data;
`else
  logic w_unused;

  assign w_unused  = ^{i_rf_we, i_wr_addr, i_wr_data, i_rs_addr};
  assign o_rs_data = i_rs_data;
`endif

endmodule
`default_nettype wire

// File: rtl/rv32i_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_rf_write_arbiter
// Description : Writeback vs mul/div register-file write port arbiter with
//               starvation guard; RF_WRITE_BYPASS_EN enables read forwarding.
// Revision    : 1.0
// ============================================================================
module rv32i_rf_write_arbiter
  import rv32i_pkg::*;
#(
  parameter int unsigned WIDTH        = C_WIDTH,
  parameter int unsigned ADDR_WIDTH   = C_ADDR_WIDTH,
  parameter int unsigned STARVE_LIMIT = C_STARVE_LIMIT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  rv32i_rf_write_arbiter_if.slave        bus
);

  localparam int unsigned           CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]      C_LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rf_we_q, rf_we_d;
  logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [WIDTH-1:0]      rf_data_q, rf_data_d;

  logic w_wb_ready, w_md_ready, w_wb_xfer, w_md_xfer;

  always_comb begin
    w_wb_ready = 1'b1;
    w_md_ready = !bus.i_wb_valid;
    if (state_q == ARB_MD) begin
      w_md_ready = 1'b1;
      w_wb_ready = !bus.i_md_valid;
    end
  end

  // Readies drop the instant reset asserts, independent of the clock
  assign bus.o_wb_ready = rst_n & w_wb_ready;
  assign bus.o_md_ready = rst_n & w_md_ready;
  assign w_wb_xfer      = bus.i_wb_valid & w_wb_ready;
  assign w_md_xfer      = bus.i_md_valid & w_md_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (w_md_xfer) begin
      cnt_d = '0;
    end else if (bus.i_md_valid && (cnt_q != C_LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (state_q == ARB_WB) begin
      if (cnt_d == C_LIMIT) state_d = ARB_MD;
    end else if (w_md_xfer || !bus.i_md_valid) begin
      state_d = ARB_WB;
      cnt_d   = '0;
    end
  end

  always_comb begin
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (w_wb_xfer) begin
      rf_we_d   = |bus.i_wb_rd_addr;
      rf_addr_d = bus.i_wb_rd_addr;
      rf_data_d = bus.i_wb_rd_data;
    end else if (w_md_xfer) begin
      rf_we_d   = |bus.i_md_rd_addr;
      rf_addr_d = bus.i_md_rd_addr;
      rf_data_d = bus.i_md_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_WB;
      cnt_q     <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  assign bus.o_rf_we      = rf_we_q;
  assign bus.o_rf_rd_addr = rf_addr_q;
  assign bus.o_rf_rd_data = rf_data_q;

  rv32i_rf_bypass #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bypass_rs1 (
    .i_rf_we   (rf_we_q),
    .i_wr_addr (rf_addr_q),
    .i_wr_data (rf_data_q),
    .i_rs_addr (bus.i_rs1_addr),
    .i_rs_data (bus.i_rf_rs1_data),
    .o_rs_data (bus.o_rs1_data)
  );

  rv32i_rf_bypass #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bypass_rs2 (
    .i_rf_we   (rf_we_q),
    .i_wr_addr (rf_addr_q),
    .i_wr_data (rf_data_q),
    .i_rs_addr (bus.i_rs2_addr),
    .i_rs_data (bus.i_rf_rs2_data),
    .o_rs_data (bus.o_rs2_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_rv32i_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32i_rf_write_arbiter
// Description : Vector table, randomized reference model and reset sequence.
// Revision    : 1.0
// ============================================================================
module tb_rv32i_rf_write_arbiter;

  localparam int STARVE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv32i_rf_write_arbiter_if #(.WIDTH(32), .ADDR_WIDTH(5)) bus ();

  rv32i_rf_write_arbiter #(.WIDTH(32), .ADDR_WIDTH(5), .STARVE_LIMIT(STARVE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Environment register file, written from the expected write stream
  logic [31:0] rf_mem [32];
  assign bus.i_rf_rs1_data = (bus.i_rs1_addr == 5'd0) ? 32'd0 : rf_mem[bus.i_rs1_addr];
  assign bus.i_rf_rs2_data = (bus.i_rs2_addr == 5'd0) ? 32'd0 : rf_mem[bus.i_rs2_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wv; logic [4:0] wa; logic [31:0] wd;
    logic        mv; logic [4:0] ma; logic [31:0] md;
    logic [4:0]  rs;
    logic        ewr, emr, ewe;
    logic [4:0]  eaddr; logic [31:0] edata;
    logic [31:0] ers_byp, ers_raw;
  } vec_t;

  function automatic vec_t mk(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                              input logic mv, input logic [4:0] ma, input logic [31:0] md,
                              input logic [4:0] rs, input logic ewr, input logic emr,
                              input logic ewe, input logic [4:0] eaddr, input logic [31:0] edata,
                              input logic [31:0] ers_byp, input logic [31:0] ers_raw);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd; v.mv = mv; v.ma = ma; v.md = md; v.rs = rs;
    v.ewr = ewr; v.emr = emr; v.ewe = ewe; v.eaddr = eaddr; v.edata = edata;
    v.ers_byp = ers_byp; v.ers_raw = ers_raw;
    return v;
  endfunction

  // Reference model: requesters, consecutive-denial count, registered write
  logic        wb_pend, md_pend;
  logic [4:0]  wb_a, md_a, rs1, rs2;
  logic [31:0] wb_d, md_d;
  int          m_wait;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  function automatic logic [31:0] exp_rs(input logic [4:0] a);
`ifdef RF_WRITE_BYPASS_EN
    if (m_we && (m_addr == a) && (a != 5'd0)) return m_data;
`endif
    return (a == 5'd0) ? 32'd0 : rf_mem[a];
  endfunction

  task automatic model_cycle();
    logic forced, e_wr, e_mr, wx, mx;
    bus.i_wb_valid = wb_pend; bus.i_wb_rd_addr = wb_a; bus.i_wb_rd_data = wb_d;
    bus.i_md_valid = md_pend; bus.i_md_rd_addr = md_a; bus.i_md_rd_data = md_d;
    bus.i_rs1_addr = rs1;     bus.i_rs2_addr = rs2;
    // mul/div wins once it has been refused STARVE times in a row
    forced = md_pend && (m_wait >= STARVE);
    e_wr   = forced ? !md_pend : 1'b1;
    e_mr   = forced ? 1'b1 : !wb_pend;
    @(negedge clk);
    chk("m_wb_ready", bus.o_wb_ready, e_wr);
    chk("m_md_ready", bus.o_md_ready, e_mr);
    chk("m_rf_we",    bus.o_rf_we, m_we);
    chk("m_rf_addr",  bus.o_rf_rd_addr, m_addr);
    chk("m_rf_data",  bus.o_rf_rd_data, m_data);
    chk("m_rs1",      bus.o_rs1_data, exp_rs(rs1));
    chk("m_rs2",      bus.o_rs2_data, exp_rs(rs2));
    @(posedge clk);
    if (m_we) rf_mem[m_addr] = m_data;
    wx = wb_pend && e_wr;
    mx = md_pend && e_mr;
    m_we = 1'b0;
    if (wx) begin
      m_we = (wb_a != 5'd0); m_addr = wb_a; m_data = wb_d; wb_pend = 1'b0;
    end else if (mx) begin
      m_we = (md_a != 5'd0); m_addr = md_a; m_data = md_d;
    end
    if (mx) begin
      m_wait = 0; md_pend = 1'b0;
    end else if (md_pend) begin
      m_wait++;
    end
    #1;
  endtask

  vec_t tbl [19];

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
    //            wv wa     wd            mv ma      md            rs     ewr emr ewe eaddr  edata         byp           raw
    tbl[0]  = mk(1, 5'd1,  32'hAAAAAAAA, 0, 5'd0,  32'h0,        5'd0,  1,  0,  0,  5'd0,  32'h0,        32'h0,        32'h0);
    tbl[1]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd1,  1,  1,  1,  5'd1,  32'hAAAAAAAA, 32'hAAAAAAAA, 32'h0);
    tbl[2]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd1,  1,  1,  0,  5'd1,  32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA);
    tbl[3]  = mk(1, 5'd2,  32'hBBBBBBBB, 1, 5'd3,  32'h11111111, 5'd0,  1,  0,  0,  5'd1,  32'hAAAAAAAA, 32'h0,        32'h0);
    tbl[4]  = mk(0, 5'd0,  32'h0,        1, 5'd3,  32'h11111111, 5'd0,  1,  1,  1,  5'd2,  32'hBBBBBBBB, 32'h0,        32'h0);
    tbl[5]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd0,  1,  1,  1,  5'd3,  32'h11111111, 32'h0,        32'h0);
    tbl[6]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd3,  1,  1,  0,  5'd3,  32'h11111111, 32'h11111111, 32'h11111111);
    tbl[7]  = mk(1, 5'd4,  32'h44400007, 1, 5'd31, 32'hC0DEC0DE, 5'd0,  1,  0,  0,  5'd3,  32'h11111111, 32'h0,        32'h0);
    tbl[8]  = mk(1, 5'd4,  32'h44400008, 1, 5'd31, 32'hC0DEC0DE, 5'd0,  1,  0,  1,  5'd4,  32'h44400007, 32'h0,        32'h0);
    tbl[9]  = mk(1, 5'd4,  32'h44400009, 1, 5'd31, 32'hC0DEC0DE, 5'd0,  1,  0,  1,  5'd4,  32'h44400008, 32'h0,        32'h0);
    tbl[10] = mk(1, 5'd4,  32'h4440000A, 1, 5'd31, 32'hC0DEC0DE, 5'd0,  1,  0,  1,  5'd4,  32'h44400009, 32'h0,        32'h0);
    tbl[11] = mk(1, 5'd4,  32'h4440000B, 1, 5'd31, 32'hC0DEC0DE, 5'd0,  0,  1,  1,  5'd4,  32'h4440000A, 32'h0,        32'h0);
    tbl[12] = mk(1, 5'd4,  32'h4440000B, 0, 5'd0,  32'h0,        5'd0,  1,  0,  1,  5'd31, 32'hC0DEC0DE, 32'h0,        32'h0);
    tbl[13] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd0,  1,  1,  1,  5'd4,  32'h4440000B, 32'h0,        32'h0);
    tbl[14] = mk(0, 5'd0,  32'h0,        1, 5'd0,  32'hDEADBEEF, 5'd0,  1,  1,  0,  5'd4,  32'h4440000B, 32'h0,        32'h0);
    tbl[15] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd0,  1,  1,  0,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0);
    tbl[16] = mk(1, 5'd5,  32'h12345678, 0, 5'd0,  32'h0,        5'd0,  1,  0,  0,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0);
    tbl[17] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd5,  1,  1,  1,  5'd5,  32'h12345678, 32'h12345678, 32'h0);
    tbl[18] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd0,  1,  1,  0,  5'd5,  32'h12345678, 32'h0,        32'h0);

    bus.i_wb_valid = 1'b1; bus.i_wb_rd_addr = 5'd9; bus.i_wb_rd_data = 32'h99999999;
    bus.i_md_valid = 1'b1; bus.i_md_rd_addr = 5'd8; bus.i_md_rd_data = 32'h88888888;
    bus.i_rs1_addr = 5'd0; bus.i_rs2_addr = 5'd0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_wb_ready", bus.o_wb_ready, 1'b0);
    chk("rst_md_ready", bus.o_md_ready, 1'b0);
    chk("rst_rf_we",    bus.o_rf_we, 1'b0);
    chk("rst_rf_addr",  bus.o_rf_rd_addr, 5'd0);
    chk("rst_rf_data",  bus.o_rf_rd_data, 32'd0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      logic [31:0] ers;
      bus.i_wb_valid = tbl[i].wv; bus.i_wb_rd_addr = tbl[i].wa; bus.i_wb_rd_data = tbl[i].wd;
      bus.i_md_valid = tbl[i].mv; bus.i_md_rd_addr = tbl[i].ma; bus.i_md_rd_data = tbl[i].md;
      bus.i_rs1_addr = tbl[i].rs; bus.i_rs2_addr = tbl[i].rs;
`ifdef RF_WRITE_BYPASS_EN
      ers = tbl[i].ers_byp;
`else
      ers = tbl[i].ers_raw;
`endif
      @(negedge clk);
      chk($sformatf("v%0d_wb_ready", i), bus.o_wb_ready, tbl[i].ewr);
      chk($sformatf("v%0d_md_ready", i), bus.o_md_ready, tbl[i].emr);
      chk($sformatf("v%0d_rf_we", i),    bus.o_rf_we, tbl[i].ewe);
      chk($sformatf("v%0d_rf_addr", i),  bus.o_rf_rd_addr, tbl[i].eaddr);
      chk($sformatf("v%0d_rf_data", i),  bus.o_rf_rd_data, tbl[i].edata);
      chk($sformatf("v%0d_rs1", i),      bus.o_rs1_data, ers);
      chk($sformatf("v%0d_rs2", i),      bus.o_rs2_data, ers);
      @(posedge clk);
      if (tbl[i].ewe) rf_mem[tbl[i].eaddr] = tbl[i].edata;
      #1;
    end

    wb_pend = 1'b0; md_pend = 1'b0; wb_a = '0; wb_d = '0; md_a = '0; md_d = '0;
    m_wait = 0; m_we = 1'b0; m_addr = 5'd5; m_data = 32'h12345678;
    for (int c = 0; c < 400; c++) begin
      if (!wb_pend && ($urandom_range(0, 99) < 80)) begin
        wb_pend = 1'b1; wb_a = 5'($urandom); wb_d = $urandom;
      end
      if (!md_pend && ($urandom_range(0, 99) < 35)) begin
        md_pend = 1'b1; md_a = 5'($urandom); md_d = $urandom;
      end
      rs1 = $urandom_range(0, 1) ? m_addr : 5'($urandom);
      rs2 = $urandom_range(0, 1) ? m_addr : 5'($urandom);
      model_cycle();
    end

    rs1 = '0; rs2 = '0;
    for (int c = 0; c < 12; c++) model_cycle();

    // Reset between edges while a write is registered
    wb_pend = 1'b1; wb_a = 5'd7; wb_d = 32'h77777777;
    md_pend = 1'b1; md_a = 5'd8; md_d = 32'h88888888;
    rs1 = 5'd7; rs2 = 5'd7;
    model_cycle();
    bus.i_wb_valid = 1'b0;
    #2;
    chk("pre_rst_rf_we", bus.o_rf_we, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rf_we",    bus.o_rf_we, 1'b0);
    chk("mid_rst_wb_ready", bus.o_wb_ready, 1'b0);
    chk("mid_rst_md_ready", bus.o_md_ready, 1'b0);
    chk("mid_rst_rf_addr",  bus.o_rf_rd_addr, 5'd0);
    m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_wait = 0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    // Fresh starvation window: mul/div must be refused exactly STARVE times
    for (int c = 0; c < 7; c++) begin
      if (!wb_pend) begin
        wb_pend = 1'b1; wb_a = 5'd9; wb_d = 32'h90000000 + c;
      end
      model_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
